// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the write-queue entry type for the write-back port arbiter
package wb_pkg;
  localparam int REG_W   = 16;
  localparam int RADDR_W = 3;
  localparam int NREGS   = 8;
  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rd;
    logic [REG_W-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_wrq.sv
// wb_wrq: circular write queue for LLU results with squash-by-register and pending mask
module wb_wrq
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq,
  input  logic [RADDR_W-1:0]           enq_rd,
  input  logic [REG_W-1:0]             enq_data,
  input  logic                         deq,
  input  logic                         squash,
  input  logic [RADDR_W-1:0]           squash_rd,
  output wb_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [NREGS-1:0]             pend_mask
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  wb_entry_t      q [DEPTH];
  logic [PW-1:0]  wp, rp;
  // slot storage and pointers; squashed slots stay occupied but lose their valid bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash && q[i].valid && q[i].rd == squash_rd) q[i].valid <= 1'b0;
      if (deq) q[rp].valid <= 1'b0;
      if (enq) q[wp] <= '{valid: 1'b1, rd: enq_rd, data: enq_data};
      wp    <= wp + PW'(enq);
      rp    <= rp + PW'(deq);
      count <= count + CW'(enq) - CW'(deq);
    end
  end
  assign head = q[rp];
  // registers still owed a write by a live queue entry
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (q[i].valid) pend_mask[q[i].rd] = 1'b1;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline write-back and LLU results
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_wr_en,
  input  logic [RADDR_W-1:0] pipe_wr_reg,
  input  logic [REG_W-1:0]   pipe_wr_data,
  input  logic               llu_valid,
  input  logic [RADDR_W-1:0] llu_reg,
  input  logic [REG_W-1:0]   llu_data,
  output logic               llu_ready,
  output logic               rf_wr_en,
  output logic [RADDR_W-1:0] rf_wr_reg,
  output logic [REG_W-1:0]   rf_wr_data,
  output logic               pipe_stall,
  output logic [NREGS-1:0]   pend_mask
);
  localparam int AW = $clog2(STARVE_LIMIT+1);
  wb_entry_t                    head;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic [AW-1:0]                age;
  logic nonempty, xfer, pipe_gnt, bypass, deq, enq, head_gnt;
  // grant priority: forced drain, pipeline, queue head, bypass; nothing is granted while in reset
  always_comb begin
    nonempty   = count != '0;
    llu_ready  = int'(count) < DEPTH;
    xfer       = llu_valid & llu_ready;
    pipe_stall = (age == AW'(STARVE_LIMIT)) & head.valid;
    pipe_gnt   = rst & ~pipe_stall & pipe_wr_en;
    bypass     = rst & ~pipe_stall & ~pipe_wr_en & ~nonempty & xfer;
    deq        = pipe_stall | (~pipe_wr_en & nonempty);
    enq        = xfer & ~bypass;
    head_gnt   = deq & head.valid;
    rf_wr_en   = pipe_gnt | bypass | head_gnt;
    rf_wr_reg  = pipe_gnt ? pipe_wr_reg  : bypass ? llu_reg  : head_gnt ? head.rd   : '0;
    rf_wr_data = pipe_gnt ? pipe_wr_data : bypass ? llu_data : head_gnt ? head.data : '0;
  end
  // head age: counts ungranted cycles of a live head, saturating at the starvation limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) age <= '0;
    else age <= (deq || !nonempty) ? '0 :
                (head.valid && age != AW'(STARVE_LIMIT)) ? age + AW'(1) : age;
  end
  wb_wrq #(.DEPTH(DEPTH)) u_wrq (
    .clk       (clk),
    .rst       (rst),
    .enq       (enq),
    .enq_rd    (llu_reg),
    .enq_data  (llu_data),
    .deq       (deq),
    .squash    (pipe_gnt),
    .squash_rd (pipe_wr_reg),
    .head      (head),
    .count     (count),
    .pend_mask (pend_mask)
  );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random checks of the write-port arbiter against a queue model
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic        clk = 1'b0, rst = 1'b0;
  logic        pipe_wr_en = 1'b0, llu_valid = 1'b0;
  logic [2:0]  pipe_wr_reg = '0, llu_reg = '0;
  logic [15:0] pipe_wr_data = '0, llu_data = '0;
  logic        llu_ready, rf_wr_en, pipe_stall;
  logic [2:0]  rf_wr_reg;
  logic [15:0] rf_wr_data;
  logic [7:0]  pend_mask;
  always #5 clk = ~clk;
  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_reg(pipe_wr_reg), .pipe_wr_data(pipe_wr_data),
    .llu_valid(llu_valid), .llu_reg(llu_reg), .llu_data(llu_data), .llu_ready(llu_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .pipe_stall(pipe_stall), .pend_mask(pend_mask)
  );
  typedef struct {bit v; bit [2:0] r; bit [15:0] d;} ment_t;
  ment_t       mq[$];
  int          mage = 0;
  bit [15:0]   mrf [8];
  bit          mw [8];
  logic [15:0] dut_rf [8];
  int          ntests = 0, nfail = 0;
  always @(posedge clk) if (rf_wr_en) dut_rf[rf_wr_reg] <= rf_wr_data;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit pwe, input bit [2:0] pr, input bit [15:0] pd,
                      input bit lv, input bit [2:0] lr, input bit [15:0] ld, output bit acc);
    bit ready, xfer, stall, ewe, deq, byp, hv;
    bit [2:0] ereg;
    bit [15:0] edat;
    bit [7:0] epend;
    @(negedge clk);
    pipe_wr_en = pwe; pipe_wr_reg = pr; pipe_wr_data = pd;
    llu_valid = lv; llu_reg = lr; llu_data = ld;
    #1;
    ready = mq.size() < DEPTH;
    xfer  = lv && ready;
    hv    = mq.size() > 0 && mq[0].v;
    stall = mage == LIMIT && hv;
    epend = '0;
    foreach (mq[i]) if (mq[i].v) epend[mq[i].r] = 1'b1;
    ewe = 0; ereg = '0; edat = '0; deq = 0; byp = 0;
    if (stall) begin
      ewe = 1; ereg = mq[0].r; edat = mq[0].d; deq = 1;
    end else if (pwe) begin
      ewe = 1; ereg = pr; edat = pd;
      foreach (mq[i]) if (mq[i].r == pr) mq[i].v = 0;
    end else if (mq.size() > 0) begin
      ewe = mq[0].v; ereg = hv ? mq[0].r : '0; edat = hv ? mq[0].d : '0; deq = 1;
    end else if (xfer) begin
      ewe = 1; ereg = lr; edat = ld; byp = 1;
    end
    chk("llu_ready", llu_ready, ready);
    chk("pipe_stall", pipe_stall, stall);
    chk("rf_wr_en", rf_wr_en, ewe);
    chk("rf_wr_reg", rf_wr_reg, ereg);
    chk("rf_wr_data", rf_wr_data, edat);
    chk("pend_mask", pend_mask, epend);
    if (ewe) begin mrf[ereg] = edat; mw[ereg] = 1; end
    if (deq || mq.size() == 0) mage = 0;
    else if (hv && mage < LIMIT) mage++;
    if (deq) void'(mq.pop_front());
    if (xfer && !byp) mq.push_back('{1'b1, lr, ld});
    acc = xfer;
  endtask
  initial begin
    bit acc, lv;
    bit [2:0] lr;
    bit [15:0] ld;
    #1;
    chk("rst_en", rf_wr_en, 1'b0);
    chk("rst_stall", pipe_stall, 1'b0);
    chk("rst_pend", pend_mask, 8'h00);
    chk("rst_ready", llu_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // bypass into an empty queue
    step(0, 0, 0, 1, 3, 16'h1234, acc);
    chk("byp_reg", rf_wr_reg, 3'd3);
    chk("byp_data", rf_wr_data, 16'h1234);
    step(0, 0, 0, 0, 0, 0, acc);
    chk("byp_pend", pend_mask, 8'h00);
    // queue behind a pipeline write, then drain
    step(1, 1, 16'hAAAA, 1, 2, 16'h0BEE, acc);
    chk("qd_pipe", rf_wr_data, 16'hAAAA);
    step(0, 0, 0, 0, 0, 0, acc);
    chk("qd_pend", pend_mask, 8'h04);
    chk("qd_data", rf_wr_data, 16'h0BEE);
    // fill the queue, then starve the head until a forced drain
    step(1, 0, 16'hC0DE, 1, 4, 16'h4444, acc);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 16'hC0DE, 1, (i == 1) ? 3'd6 : 3'd7, (i == 1) ? 16'h6666 : 16'h7777, acc);
      if (i == 2) begin
        chk("full_ready", llu_ready, 1'b0);
        chk("full_pend", pend_mask, 8'h50);
      end
      chk("starve_stall", pipe_stall, i == 5);
      if (i == 5) chk("starve_reg", rf_wr_reg, 3'd4);
    end
    repeat (4) step(0, 0, 0, 0, 0, 0, acc);
    // squash a queued result by a younger pipeline write to the same register
    step(1, 0, 16'h0101, 1, 5, 16'h1111, acc);
    step(1, 5, 16'h2222, 0, 0, 0, acc);
    chk("sq_pend_before", pend_mask, 8'h20);
    step(0, 0, 0, 0, 0, 0, acc);
    chk("sq_pend_after", pend_mask, 8'h00);
    chk("sq_deq_en", rf_wr_en, 1'b0);
    // asynchronous reset with two entries queued
    step(1, 1, 16'h0001, 1, 2, 16'h2020, acc);
    step(1, 1, 16'h0002, 1, 3, 16'h3030, acc);
    @(negedge clk);
    pipe_wr_en = 1; llu_valid = 0;
    #2 rst = 1'b0;
    #1;
    chk("ar_en", rf_wr_en, 1'b0);
    chk("ar_stall", pipe_stall, 1'b0);
    chk("ar_pend", pend_mask, 8'h00);
    chk("ar_ready", llu_ready, 1'b1);
    chk("ar_reg", rf_wr_reg, 3'd0);
    mq.delete(); mage = 0;
    @(negedge clk);
    pipe_wr_en = 0;
    rst = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0, 0, acc);
    // random traffic with the LLU holding each result until accepted
    lv = 0; lr = '0; ld = '0;
    for (int c = 0; c < 400; c++) begin
      if (!lv && $urandom_range(0, 99) < 55) begin
        lv = 1; lr = 3'($urandom); ld = 16'($urandom);
      end
      step($urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom), lv, lr, ld, acc);
      if (acc) lv = 0;
    end
    repeat (8) step(0, 0, 0, 0, 0, 0, acc);
    @(negedge clk);
    for (int r = 0; r < 8; r++) if (mw[r]) chk("rf_final", dut_rf[r], mrf[r]);
    chk("sq_r5_final", dut_rf[5], mrf[5]);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
